rram_bank_array_ctrl: RTL

- Parametrised successor to the team's fixed 52-bank BRAM-based RRAM emulator.
- N_BANKS identical behavioural memory banks sit behind one valid/ready request port, with a selectable bitwise read-combine mode: AND, OR or majority.
- Adds sequential behaviour the fixed emulator lacks: power-up init sweep, per-bank write masking, stuck-at-0 fault injection, and write-verify with bounded retry.
- Sits between the test sequencer and the emulated crossbar.

---
 rtl/rram_bank_array_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rram_bank_array_ctrl.sv
// Parametrised RRAM bank-array emulator: N identical banks behind one valid/ready port,
// with power-up init sweep, masked writes, stuck-at-0 injection and bounded write-verify retry.
module rram_bank_array_ctrl #(
  parameter int N_BANKS   = 52,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [N_BANKS-1:0] req_bank_mask,
  input  logic [1:0]         req_mode,
  input  logic [N_BANKS-1:0] fault_mask,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(N_BANKS + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD    = 3'd2,
    ST_RRESP = 3'd3,
    ST_WR    = 3'd4,
    ST_WV    = 3'd5,
    ST_WCHK  = 3'd6
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          init_addr_q, init_addr_d;
  logic [RTY_W-1:0]           retry_q, retry_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [N_BANKS-1:0]         mask_q, mask_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]          resp_rdata_q, resp_rdata_d;
  logic                       resp_err_q, resp_err_d;

  logic [DATA_W-1:0]          mem_q [N_BANKS][DEPTH];
  logic [N_BANKS-1:0][DATA_W-1:0] rd_q;
  logic [N_BANKS-1:0]         mem_we_s;
  logic [ADDR_W-1:0]          mem_addr_s;
  logic [DATA_W-1:0]          mem_wdata_s;
  logic [DATA_W-1:0]          combined_s;

  // Per-bit vote over all banks; reserved mode 3 falls back to AND.
  function automatic logic [DATA_W-1:0] combine_banks(
    input logic [N_BANKS-1:0][DATA_W-1:0] data,
    input logic [1:0]                     mode
  );
    logic [DATA_W-1:0] res;
    logic [CNT_W-1:0]  cnt;
    res = '0;
    for (int b = 0; b < DATA_W; b++) begin
      cnt = '0;
      for (int k = 0; k < N_BANKS; k++) begin
        cnt = cnt + CNT_W'(data[k][b]);
      end
      case (mode)
        2'd1:    res[b] = (cnt != '0);
        2'd2:    res[b] = (cnt > CNT_W'(N_BANKS / 2));
        default: res[b] = (cnt == CNT_W'(N_BANKS));
      endcase
    end
    return res;
  endfunction

  // Bank arrays and read register; stuck-at faults mask the registered read only.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_BANKS; k++) begin
      if (mem_we_s[k]) begin
        mem_q[k][mem_addr_s] <= mem_wdata_s;
      end
      rd_q[k] <= fault_mask[k] ? '0 : mem_q[k][mem_addr_s];
    end
  end

  // Bank address/write selection: init sweep owns the array until IDLE.
  always_comb begin
    mem_we_s    = '0;
    mem_addr_s  = addr_q;
    mem_wdata_s = wdata_q;
    if (state_q == ST_INIT) begin
      mem_we_s    = '1;
      mem_addr_s  = init_addr_q;
      mem_wdata_s = '1;
    end else if (state_q == ST_WR) begin
      mem_we_s = mask_q;
    end else begin
      mem_we_s = '0;
    end
  end

  assign combined_s = combine_banks(rd_q, mode_q);

  // Next-state and response logic.
  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    retry_d      = retry_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    mode_d       = mode_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_INIT: begin
        if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
          init_addr_d = '0;
          state_d     = ST_IDLE;
        end else begin
          init_addr_d = init_addr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mask_d  = req_bank_mask;
          mode_d  = req_mode;
          retry_d = '0;
          state_d = req_we ? ST_WR : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD:    state_d = ST_RRESP;
      ST_RRESP: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = combined_s;
        resp_err_d   = 1'b0;
        state_d      = ST_IDLE;
      end
      ST_WR:    state_d = ST_WV;
      ST_WV:    state_d = ST_WCHK;
      ST_WCHK: begin
        if (combined_s == wdata_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = combined_s;
          resp_err_d   = 1'b0;
          retry_d      = '0;
          state_d      = ST_IDLE;
        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = ST_WR;
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = combined_s;
          resp_err_d   = 1'b1;
          retry_d      = '0;
          state_d      = ST_IDLE;
        end
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      retry_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      mode_q       <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      retry_q      <= retry_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
